// File: rtl/ddr2_sdram_local_pattern_tester_if.sv
// Local (Avalon-style) request/response bus between the pattern tester and the DDR2 controller.
// The tester is the master and the controller is the slave.
interface ddr2_sdram_local_pattern_tester_if #(
    parameter int unsigned LOCAL_DATA_BITS = 64,
    parameter int unsigned MEM_CHIP_BITS   = 1,
    parameter int unsigned MEM_ROW_BITS    = 13,
    parameter int unsigned MEM_BANK_BITS   = 2,
    parameter int unsigned MEM_COL_BITS    = 10
);
    logic                           local_init_done;
    logic                           local_ready;
    logic                           local_rdata_valid;
    logic [LOCAL_DATA_BITS-1:0]     local_rdata;
    logic                           local_read_req;
    logic                           local_write_req;
    logic                           local_burstbegin;
    logic                           local_size;
    logic                           local_autopch_req;
    logic [MEM_CHIP_BITS-1:0]       local_cs_addr;
    logic [MEM_ROW_BITS-1:0]        local_row_addr;
    logic [MEM_BANK_BITS-1:0]       local_bank_addr;
    logic [MEM_COL_BITS-2:0]        local_col_addr;
    logic [LOCAL_DATA_BITS-1:0]     local_wdata;
    logic [LOCAL_DATA_BITS/8-1:0]   local_be;

    modport master (
        input  local_init_done, local_ready, local_rdata_valid, local_rdata,
        output local_read_req, local_write_req, local_burstbegin, local_size, local_autopch_req,
        output local_cs_addr, local_row_addr, local_bank_addr, local_col_addr, local_wdata,
        output local_be
    );

    modport slave (
        output local_init_done, local_ready, local_rdata_valid, local_rdata,
        input  local_read_req, local_write_req, local_burstbegin, local_size, local_autopch_req,
        input  local_cs_addr, local_row_addr, local_bank_addr, local_col_addr, local_wdata,
        input  local_be
    );
endinterface

// File: rtl/ddr2_sdram_local_pattern_tester.sv
// Memory self-test master: writes an address-derived pattern to NUM_WORDS local words, reads
// them back in order with a bounded number of reads in flight, and reports errors/timeouts.
module ddr2_sdram_local_pattern_tester #(
    parameter int unsigned LOCAL_DATA_BITS = 64,
    parameter int unsigned MEM_CHIP_BITS   = 1,
    parameter int unsigned MEM_ROW_BITS    = 13,
    parameter int unsigned MEM_BANK_BITS   = 2,
    parameter int unsigned MEM_COL_BITS    = 10,
    parameter int unsigned NUM_WORDS       = 256,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned RD_TIMEOUT      = 1023
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    ddr2_sdram_local_pattern_tester_if.master local_bus,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic                              timeout,
    output logic [15:0]                       err_count,
    output logic [23:0]                       first_err_addr
);
    localparam int unsigned COL_W  = MEM_COL_BITS - 1;
    localparam int unsigned ADDR_W = MEM_CHIP_BITS + MEM_ROW_BITS + MEM_BANK_BITS + COL_W;
    localparam int unsigned HALF   = LOCAL_DATA_BITS / 2;
    localparam int unsigned IDX_W  = $clog2(NUM_WORDS + 1);
    localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned WD_W   = $clog2(RD_TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0] NUM_IDX  = IDX_W'(NUM_WORDS);
    localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StWaitInit, StWrite, StRead, StDrain, StDone} state_e;

    state_e                     state;
    logic [IDX_W-1:0]           req_idx, chk_idx, req_idx_next;
    logic [OUT_W-1:0]           outstanding, out_next;
    logic [WD_W-1:0]            wd_cnt;
    logic                       read_req, write_req;
    logic [ADDR_W-1:0]          addr;
    logic [LOCAL_DATA_BITS-1:0] wdata;
    logic                       wr_acc, rd_acc, rd_ret, checking, mismatch, wd_expire;

    function automatic logic [LOCAL_DATA_BITS-1:0] pattern(input logic [IDX_W-1:0] idx);
        logic [HALF-1:0] lo;
        lo = HALF'(idx);
        return {~lo, lo};
    endfunction

    always_comb begin
        wr_acc       = write_req && local_bus.local_ready;
        rd_acc       = read_req && local_bus.local_ready;
        checking     = (state == StRead) || (state == StDrain);
        // Valid beats with nothing in flight are stray and must not advance the checker.
        rd_ret       = checking && local_bus.local_rdata_valid && (outstanding != '0);
        mismatch     = local_bus.local_rdata != pattern(chk_idx);
        req_idx_next = rd_acc ? req_idx + IDX_W'(1) : req_idx;
        out_next     = outstanding;
        if (rd_acc && !rd_ret) begin
            out_next = outstanding + OUT_W'(1);
        end else if (!rd_acc && rd_ret) begin
            out_next = outstanding - OUT_W'(1);
        end
        wd_expire    = checking && !local_bus.local_rdata_valid && (outstanding != '0) &&
                       (wd_cnt == WD_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= StIdle;
            req_idx        <= '0;
            chk_idx        <= '0;
            outstanding    <= '0;
            wd_cnt         <= '0;
            read_req       <= 1'b0;
            write_req      <= 1'b0;
            addr           <= '0;
            wdata          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        state          <= StWaitInit;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        timeout        <= 1'b0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        req_idx        <= '0;
                        chk_idx        <= '0;
                        outstanding    <= '0;
                        wd_cnt         <= '0;
                    end
                end
                StWaitInit: begin
                    if (local_bus.local_init_done) begin
                        state     <= StWrite;
                        write_req <= 1'b1;
                        addr      <= '0;
                        wdata     <= pattern('0);
                    end
                end
                StWrite: begin
                    if (wr_acc) begin
                        if (req_idx == LAST_IDX) begin
                            state     <= StRead;
                            write_req <= 1'b0;
                            read_req  <= 1'b1;
                            req_idx   <= '0;
                            addr      <= '0;
                        end else begin
                            req_idx <= req_idx + IDX_W'(1);
                            addr    <= ADDR_W'(req_idx + IDX_W'(1));
                            wdata   <= pattern(req_idx + IDX_W'(1));
                        end
                    end
                end
                StRead: begin
                    if (rd_acc) begin
                        req_idx <= req_idx_next;
                        addr    <= ADDR_W'(req_idx_next);
                    end
                    // A held request stays up: outstanding cannot grow until it is accepted.
                    if (rd_acc && (req_idx_next == NUM_IDX)) begin
                        state    <= StDrain;
                        read_req <= 1'b0;
                    end else begin
                        read_req <= out_next < MAX_OUT;
                    end
                end
                StDrain: begin
                    if (chk_idx == NUM_IDX) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0);
                    end
                end
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase

            if (checking) begin
                outstanding <= out_next;
                if (local_bus.local_rdata_valid || (outstanding == '0)) begin
                    wd_cnt <= '0;
                end else begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                end
                if (rd_ret) begin
                    chk_idx <= chk_idx + IDX_W'(1);
                    if (mismatch) begin
                        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                        if (err_count == '0) first_err_addr <= 24'(chk_idx);
                    end
                end
                if (wd_expire) begin
                    state    <= StDone;
                    timeout  <= 1'b1;
                    read_req <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    pass     <= 1'b0;
                end
            end
        end
    end

    assign local_bus.local_read_req    = read_req;
    assign local_bus.local_write_req   = write_req;
    assign local_bus.local_burstbegin  = read_req | write_req;
    assign local_bus.local_size        = 1'b1;
    assign local_bus.local_autopch_req = 1'b0;
    assign {local_bus.local_cs_addr, local_bus.local_row_addr, local_bus.local_bank_addr,
            local_bus.local_col_addr} = addr;
    assign local_bus.local_wdata       = wdata;
    assign local_bus.local_be          = '1;
endmodule

// File: tb/tb_ddr2_sdram_local_pattern_tester.sv
// Bench for the local-bus pattern tester: a randomized responder with an in-order read queue
// and a word memory, checked against results computed from the test rules.
module tb_ddr2_sdram_local_pattern_tester;
    localparam int unsigned DW = 64, CS_W = 1, ROW_W = 13, BANK_W = 2, COL_BITS = 10;
    localparam int unsigned COL_W = COL_BITS - 1;
    localparam int unsigned NW = 8, MAXO = 2, TMO = 15;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [23:0] first_err_addr;

    ddr2_sdram_local_pattern_tester_if #(
        .LOCAL_DATA_BITS(DW), .MEM_CHIP_BITS(CS_W), .MEM_ROW_BITS(ROW_W),
        .MEM_BANK_BITS(BANK_W), .MEM_COL_BITS(COL_BITS)
    ) bus ();

    ddr2_sdram_local_pattern_tester #(
        .LOCAL_DATA_BITS(DW), .MEM_CHIP_BITS(CS_W), .MEM_ROW_BITS(ROW_W),
        .MEM_BANK_BITS(BANK_W), .MEM_COL_BITS(COL_BITS), .NUM_WORDS(NW),
        .MAX_OUTSTANDING(MAXO), .RD_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .local_bus(bus),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [63:0] data;
    } rd_t;

    int          n_cmp = 0, n_bad = 0;
    int          sample = 0, wr_seen, rd_acc, rd_back, outst, outst_at_sample;
    int          ready_pct = 100, lat_min = 3, lat_max = 3, stall_left = 0;
    bit          withhold = 0, spurious = 0, last_vld = 0;
    logic [NW-1:0] corrupt = '0;
    rd_t         rq[$];
    logic [63:0] mem[int];
    bit          prev_pending = 0, prev_wr, prev_rd;
    int          prev_idx;
    logic [63:0] prev_wdata;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_pattern(input int idx);
        return {~32'(idx), 32'(idx)};
    endfunction

    // Linear word index rebuilt from the split address fields, column first.
    function automatic int bus_index();
        return int'(bus.local_col_addr) + (int'(bus.local_bank_addr) << COL_W) +
               (int'(bus.local_row_addr) << (COL_W + BANK_W)) +
               (int'(bus.local_cs_addr) << (COL_W + BANK_W + ROW_W));
    endfunction

    // One cycle: sample at negedge, act as the controller for the next rising edge.
    task automatic tick();
        int          idx, lat;
        logic        rdy, vld, wr, rd;
        logic [63:0] rdat, d;
        @(negedge clk);
        sample++;
        if (!reset_n) prev_pending = 1'b0;
        wr = bus.local_write_req;
        rd = bus.local_read_req;
        idx = bus_index();
        outst_at_sample = outst;
        if (prev_pending) begin
            check_eq("hold_req", {62'd0, wr, rd}, {62'd0, prev_wr, prev_rd});
            check_eq("hold_addr", 64'(idx), 64'(prev_idx));
            check_eq("hold_wdata", bus.local_wdata, prev_wdata);
        end
        if (wr || rd) check_eq("burstbegin", 64'(bus.local_burstbegin), 64'd1);
        if (stall_left > 0 && wr && idx == 1) begin
            rdy = 1'b0;
            stall_left--;
        end else begin
            rdy = ($urandom_range(99) < ready_pct);
        end
        vld = 1'b0;
        rdat = {$urandom, $urandom};
        if (!withhold && rq.size() > 0 && rq[0].due <= sample) begin
            vld = 1'b1;
            rdat = rq[0].data;
            rq.delete(0);
            outst--;
            rd_back++;
        end else if (spurious && outst == 0 && $urandom_range(9) == 0) begin
            vld = 1'b1;
        end
        if (wr && rdy) begin
            check_eq("wr_index", 64'(idx), 64'(wr_seen));
            check_eq("wr_data", bus.local_wdata, ref_pattern(idx));
            if (idx == 2) check_eq("wr_data_i2", bus.local_wdata, 64'hFFFFFFFD_00000002);
            mem[idx] = bus.local_wdata;
            wr_seen++;
        end
        if (rd && rdy) begin
            check_eq("rd_index", 64'(idx), 64'(rd_acc));
            lat = int'($urandom_range(lat_max, lat_min));
            d = mem.exists(idx) ? mem[idx] : 64'd0;
            if (idx >= 0 && idx < NW) begin
                if (corrupt[idx]) d = d ^ 64'd1;
            end
            rq.push_back('{due: sample + lat, data: d});
            outst++;
            rd_acc++;
            check_eq("outstanding_le_max", 64'(outst <= MAXO), 64'd1);
        end
        prev_pending = (wr || rd) && !rdy;
        prev_wr = wr;
        prev_rd = rd;
        prev_idx = idx;
        prev_wdata = bus.local_wdata;
        bus.local_ready = rdy;
        bus.local_rdata_valid = vld;
        bus.local_rdata = rdat;
        last_vld = vld;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_ctl"}, 64'({bus.local_read_req, bus.local_write_req,
                 bus.local_burstbegin, bus.local_size, bus.local_autopch_req,
                 busy, done, pass, timeout}), 64'h020);
        check_eq({tag, "_addr"}, 64'({bus.local_cs_addr, bus.local_row_addr,
                 bus.local_bank_addr, bus.local_col_addr}), 64'd0);
        check_eq({tag, "_wdata"}, bus.local_wdata, 64'd0);
        check_eq({tag, "_be"}, 64'(bus.local_be), 64'hFF);
        check_eq({tag, "_err"}, 64'(err_count), 64'd0);
        check_eq({tag, "_first"}, 64'(first_err_addr), 64'd0);
    endtask

    task automatic run_test(input string name, input int rpct, input int lmin, input int lmax,
                            input bit wh, input int init_delay, input int stall,
                            input logic [NW-1:0] corr, input bit poke, input bit spur);
        int s0, s_init, first_req, stall_cnt, exp_err, exp_first;
        bit done_seen, to_seen, exp_pass;
        ready_pct = rpct; lat_min = lmin; lat_max = lmax; withhold = wh;
        stall_left = stall; corrupt = corr; spurious = spur;
        wr_seen = 0; rd_acc = 0; rd_back = 0; outst = 0;
        rq.delete(); mem.delete();
        bus.local_init_done = (init_delay == 0);
        tick();
        start = 1'b1;
        s0 = sample;
        s_init = s0;
        first_req = -1; stall_cnt = 0; done_seen = 0; to_seen = 0;
        for (int c = 0; c < 2000 && !done_seen; c++) begin
            tick();
            start = poke && (sample == s0 + 6);
            if (sample == s0 + 1) begin
                check_eq({name, "_busy_on_start"}, 64'(busy), 64'd1);
                check_eq({name, "_done_cleared"}, 64'(done), 64'd0);
            end
            if (first_req < 0 && (bus.local_write_req || bus.local_read_req)) first_req = sample;
            if (!bus.local_init_done) begin
                check_eq({name, "_req_before_init"},
                         64'(bus.local_write_req | bus.local_read_req), 64'd0);
                if (sample >= s0 + init_delay) begin
                    bus.local_init_done = 1'b1;
                    s_init = sample;
                end
            end
            if (wh && !to_seen) begin
                if (timeout) begin
                    to_seen = 1;
                    check_eq({name, "_stall_cycles"}, 64'(stall_cnt), 64'(TMO));
                end else if (outst_at_sample > 0 && !last_vld) begin
                    stall_cnt++;
                end
            end
            if (done) done_seen = 1;
        end
        start = 1'b0;
        check_eq({name, "_done_reached"}, 64'(done_seen), 64'd1);
        exp_err = wh ? 0 : $countones(corr);
        exp_first = 0;
        if (!wh) begin
            for (int i = NW - 1; i >= 0; i--) if (corr[i]) exp_first = i;
        end
        exp_pass = !wh && exp_err == 0;
        check_eq({name, "_first_req_cycle"}, 64'(first_req - s0),
                 64'(((s_init > s0 + 1) ? s_init : s0 + 1) + 1 - s0));
        check_eq({name, "_writes"}, 64'(wr_seen), 64'(NW));
        if (!wh) check_eq({name, "_reads_returned"}, 64'(rd_back), 64'(NW));
        check_eq({name, "_busy"}, 64'(busy), 64'd0);
        check_eq({name, "_timeout"}, 64'(timeout), 64'(wh));
        check_eq({name, "_pass"}, 64'(pass), 64'(exp_pass));
        check_eq({name, "_err_count"}, 64'(err_count), 64'(exp_err));
        check_eq({name, "_first_err"}, 64'(first_err_addr), 64'(exp_first));
        tick();
        tick();
        check_eq({name, "_done_sticky"}, 64'({done, pass, busy}), 64'({1'b1, exp_pass, 1'b0}));
    endtask

    initial begin
        bit seen;
        bus.local_init_done = 1'b0;
        bus.local_ready = 1'b0;
        bus.local_rdata_valid = 1'b0;
        bus.local_rdata = '0;
        repeat (3) tick();
        check_reset("por");
        reset_n = 1'b1;

        run_test("ideal",     100, 3,  3,  0, 0, 0, 8'h00, 0, 0);
        run_test("wr_stall",  100, 3,  3,  0, 0, 5, 8'h00, 0, 0);
        run_test("corrupt",   100, 3,  3,  0, 0, 0, 8'h0C, 0, 0);
        run_test("withhold",  100, 3,  3,  1, 0, 0, 8'h00, 0, 0);
        run_test("lat10",     100, 10, 10, 0, 0, 0, 8'h00, 0, 0);
        run_test("init_wait", 100, 2,  4,  0, 6, 0, 8'h00, 0, 0);
        for (int k = 0; k < 8; k++) begin
            run_test("random", 30 + int'($urandom_range(70)), 1 + int'($urandom_range(4)),
                     5 + int'($urandom_range(6)), 0, int'($urandom_range(3)), 0,
                     8'($urandom) & 8'($urandom), k[0], 1);
        end

        // Reset while reads are in flight, then a clean run.
        ready_pct = 100; lat_min = 10; lat_max = 10; withhold = 0; spurious = 0;
        wr_seen = 0; rd_acc = 0; rd_back = 0; outst = 0; rq.delete(); mem.delete();
        corrupt = '0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            tick();
            if (bus.local_read_req) seen = 1;
        end
        check_eq("reached_read", 64'(seen), 64'd1);
        reset_n = 1'b0;
        tick();
        check_reset("mid_reset");
        reset_n = 1'b1;
        run_test("after_reset", 100, 3, 3, 0, 0, 0, 8'h00, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
